instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-low reset.
REQ-003 Port start, input, 1: one-cycle pulse that begins a load session.
REQ-004 Port byte_valid, input, 1: byte_data is valid this cycle.
REQ-005 Port byte_data, input, 8: incoming stream byte.
REQ-006 Port byte_ready, output, 1: loader accepts a byte; a transfer occurs when byte_valid and byte_ready are both high.
REQ-007 Port im_write_en, output, 1: one-cycle write strobe to the instruction memory.
REQ-008 Port im_address, output, 32: byte address of the word being written; always word-aligned, with bits [1:0] = 0.
REQ-009 Port im_write_data, output, 32: instruction word to write.
REQ-010 Port cpu_hold, output, 1: high while a session is active; holds the CPU in reset.
REQ-011 Port done, output, 1: sticky flag; the last session completed with a correct checksum.
REQ-012 Port error, output, 1: sticky flag; the last session failed.
REQ-013 Port words_loaded, output, 9: number of data words written in the current or last session.

Function
REQ-014 States: IDLE, HEADER, DATA, CHECK, FINISH, FAIL.
REQ-015 byte_ready is high only in HEADER, DATA and CHECK.
REQ-016 Byte assembly is big-endian: the 1st accepted byte of a word goes to bits [31:24] and the 4th to bits [7:0]. A 2-bit byte counter wraps 3->0 on each completed word.
REQ-017 IDLE/FINISH/FAIL + start -> HEADER; on entry, clear the byte counter, words_loaded, checksum, done and error.
REQ-018 HEADER collects a 4-byte word count N.
- N in 1..256 -> DATA.
- Otherwise -> FAIL.
REQ-019 DATA, on each completed word:
- im_write_en pulses high for exactly the cycle after the 4th byte is accepted.
- im_address = words_loaded*4 during that pulse.
- im_write_data holds the assembled word during that pulse.
- The running checksum is XORed with the word.
- words_loaded increments in the same cycle as the pulse.
REQ-020 DATA -> CHECK when words_loaded reaches N.
REQ-021 CHECK collects a 4-byte word.
- Equal to the XOR of all data words -> FINISH, done=1.
- Not equal -> FAIL, error=1.
REQ-022 FINISH and FAIL hold until the next start; cpu_hold=0 in IDLE, FINISH and FAIL, and 1 in all other states.
REQ-023 Latency: first byte of a session accepted no earlier than 1 cycle after start. A write pulse follows its 4th byte by exactly 1 cycle. done/error assert 1 cycle after the last checksum byte.
REQ-024 start while in HEADER, DATA or CHECK aborts the session and restarts it per REQ-017. Any word still being assembled is discarded with no write. Words already written stay in memory.
REQ-025 byte_valid with byte_ready low is ignored; gaps of any length between bytes are allowed.
REQ-026 N=256 writes addresses 0x000..0x3FC. Addresses never exceed 0x3FC.

Reset
REQ-027 reset low asynchronously forces:
- state=IDLE
- byte_ready, im_write_en, done, error = 0
- im_address, im_write_data = 0
- words_loaded = 0
- cpu_hold = 0
REQ-028 Reset asserted mid-session abandons the session with no further write; a pending write pulse is suppressed.
REQ-029 First start is accepted on the first clock edge after reset deasserts.

Structure
REQ-030 A shared package holds:
- the state encoding;
- MAX_WORDS=256;
- WORD_BYTES=4;
- the im_address width constant.
REQ-031 One sub-module, byte_packer, holds the byte counter, the big-endian shift register and a word_complete pulse; the loader FSM instantiates it.

Verification
REQ-032 start; header 00 00 00 03; words 20040003, 0c100005, 00000000; checksum 2C140006 -> writes at 0x0, 0x4, 0x8 with those words; done=1, words_loaded=3, cpu_hold falls.
REQ-033 Header 00 00 00 00, and separately 00 00 01 01 -> FAIL, error=1, no im_write_en pulse.
REQ-034 N=1, word 1000FFFF, checksum 00000000 -> one write at 0x0, then error=1 and done=0.
REQ-035 N=2; start re-pulsed after 6 data bytes -> one write only (at 0x0) before the abort; the new session then writes again from 0x0.
REQ-036 Reset low in the cycle the 4th byte is accepted -> no write pulse; all outputs at reset values.
REQ-037 N=256 with random inter-byte gaps -> last write at 0x3FC, words_loaded=256, done=1.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instruction_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HEADER = 3'd1,
      ST_DATA   = 3'd2,
      ST_CHECK  = 3'd3,
      ST_FINISH = 3'd4,
      ST_FAIL   = 3'd5
   } state_t;

   localparam int MAX_WORDS  = 256;
   localparam int WORD_BYTES = 4;
   localparam int IM_ADDR_W  = 32;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Big-endian byte-to-word packer; word and word_complete are valid in the cycle the last byte is accepted.
module byte_packer
   import instruction_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_complete
);

   logic [1:0]  byte_count;
   logic [23:0] shift;

   // The fourth byte is not stored; it completes the word straight off the input.
   assign word          = {shift, byte_data};
   assign word_complete = byte_en && (byte_count == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_count <= 2'd0;
         shift      <= 24'd0;
      end else if (clear) begin
         byte_count <= 2'd0;
         shift      <= 24'd0;
      end else if (byte_en) begin
         byte_count <= byte_count + 2'd1;
         shift      <= {shift[15:0], byte_data};
      end
   end

endmodule

// File: rtl/instruction_loader.sv
// Streams a length-prefixed, XOR-checksummed image into instruction memory while holding the CPU.
// Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both high.
module instruction_loader
   import instruction_loader_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 byte_valid,
   input  logic [7:0]           byte_data,
   output logic                 byte_ready,
   output logic                 im_write_en,
   output logic [IM_ADDR_W-1:0] im_address,
   output logic [31:0]          im_write_data,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 error,
   output logic [8:0]           words_loaded,
   output state_t               dbg_state
);

   state_t      state;
   logic [8:0]  word_total;
   logic [31:0] checksum;
   logic        byte_en;
   logic [31:0] word;
   logic        word_complete;

   // start takes priority so a byte arriving with it is dropped, not folded into the new session.
   assign byte_en   = byte_valid && byte_ready && !start;
   assign dbg_state = state;

   byte_packer u_packer (
      .clk           (clk),
      .reset         (reset),
      .clear         (start),
      .byte_en       (byte_en),
      .byte_data     (byte_data),
      .word          (word),
      .word_complete (word_complete)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         byte_ready    <= 1'b0;
         im_write_en   <= 1'b0;
         im_address    <= '0;
         im_write_data <= 32'd0;
         cpu_hold      <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         words_loaded  <= 9'd0;
         word_total    <= 9'd0;
         checksum      <= 32'd0;
      end else begin
         im_write_en <= 1'b0;
         if (start) begin
            state        <= ST_HEADER;
            byte_ready   <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 9'd0;
            checksum     <= 32'd0;
         end else begin
            case (state)
               ST_HEADER: begin
                  if (word_complete) begin
                     if (word != 32'd0 && word <= 32'(MAX_WORDS)) begin
                        word_total <= word[8:0];
                        state      <= ST_DATA;
                     end else begin
                        state      <= ST_FAIL;
                        error      <= 1'b1;
                        byte_ready <= 1'b0;
                        cpu_hold   <= 1'b0;
                     end
                  end
               end
               ST_DATA: begin
                  if (word_complete) begin
                     // Address uses the count before this word; both update on the same edge.
                     im_write_en   <= 1'b1;
                     im_address    <= {{(IM_ADDR_W-11){1'b0}}, words_loaded, 2'b00};
                     im_write_data <= word;
                     checksum      <= checksum ^ word;
                     words_loaded  <= words_loaded + 9'd1;
                     if (words_loaded + 9'd1 == word_total)
                        state <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  if (word_complete) begin
                     byte_ready <= 1'b0;
                     cpu_hold   <= 1'b0;
                     if (word == checksum) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                     end else begin
                        state <= ST_FAIL;
                        error <= 1'b1;
                     end
                  end
               end
               default: begin
                  byte_ready <= 1'b0;
                  cpu_hold   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: nominal load, bad header/checksum, abort, reset, max length.
module tb_instruction_loader;
   import instruction_loader_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        im_write_en;
   logic [31:0] im_address;
   logic [31:0] im_write_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [8:0]  words_loaded;
   state_t      dbg_state;

   int checks = 0;
   int passes = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] exp_q[$];

   instruction_loader dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .im_write_en   (im_write_en),
      .im_address    (im_address),
      .im_write_data (im_write_data),
      .cpu_hold      (cpu_hold),
      .done          (done),
      .error         (error),
      .words_loaded  (words_loaded),
      .dbg_state     (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // write monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (im_write_en) begin
         wr_addr_q.push_back(im_address);
         wr_data_q.push_back(im_write_data);
      end
   end

   // driver tasks
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      idle_cycles(gap);
      byte_valid = 1'b1;
      byte_data  = b;
      waited     = 0;
      while (!byte_ready && waited < 100) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checks++;
      if (waited >= 100) begin
         $display("FAIL handshake_timeout: byte_ready=%0b required=1", byte_ready);
      end else begin
         passes++;
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 3; i >= 0; i--)
         send_byte(w[i*8 +: 8], $urandom_range(0, max_gap));
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      exp_q.delete();
   endtask

   // scenarios
   task automatic test_reset();
      reset = 1'b0;
      idle_cycles(3);
      checks++;
      if ({byte_ready, im_write_en, cpu_hold, done, error} !== 5'b0) begin
         $display("FAIL reset_flags: got=%b required=00000", {byte_ready, im_write_en, cpu_hold, done, error});
      end else passes++;
      checks++;
      if (im_address !== 32'd0 || im_write_data !== 32'd0 || words_loaded !== 9'd0) begin
         $display("FAIL reset_data: addr=%h data=%h words=%0d required=0/0/0", im_address, im_write_data, words_loaded);
      end else passes++;
      checks++;
      if (dbg_state !== ST_IDLE) begin
         $display("FAIL reset_state: got=%0d required=%0d", dbg_state, ST_IDLE);
      end else passes++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_basic_load();
      clear_log();
      exp_q.push_back(32'h20040003);
      exp_q.push_back(32'h0c100005);
      exp_q.push_back(32'h00000000);
      @(posedge clk);
      #1;
      pulse_start();
      checks++;
      if (cpu_hold !== 1'b1 || byte_ready !== 1'b1) begin
         $display("FAIL start_hold: cpu_hold=%b byte_ready=%b required=1/1", cpu_hold, byte_ready);
      end else passes++;
      send_word(32'h00000003, 0);
      send_word(32'h20040003, 1);
      checks++;
      if (im_write_en !== 1'b1 || im_address !== 32'h0 || im_write_data !== 32'h20040003) begin
         $display("FAIL write_latency: en=%b addr=%h data=%h required=1/0/20040003", im_write_en, im_address, im_write_data);
      end else passes++;
      send_word(32'h0c100005, 2);
      send_word(32'h00000000, 0);
      send_word(32'h2C140006, 1);
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 9'd3 || cpu_hold !== 1'b0) begin
         $display("FAIL basic_status: done=%b error=%b words=%0d hold=%b required=1/0/3/0", done, error, words_loaded, cpu_hold);
      end else passes++;
      checks++;
      if (wr_addr_q.size() != 3) begin
         $display("FAIL basic_write_count: got=%0d required=3", wr_addr_q.size());
      end else begin
         if (wr_addr_q[0] !== 32'h0 || wr_addr_q[1] !== 32'h4 || wr_addr_q[2] !== 32'h8 ||
             wr_data_q[0] !== exp_q[0] || wr_data_q[1] !== exp_q[1] || wr_data_q[2] !== exp_q[2]) begin
            $display("FAIL basic_writes: %h=%h %h=%h %h=%h required 0=%h 4=%h 8=%h",
                     wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1], wr_addr_q[2], wr_data_q[2],
                     exp_q[0], exp_q[1], exp_q[2]);
         end else passes++;
      end
   endtask

   task automatic test_bad_header(input logic [31:0] n);
      clear_log();
      pulse_start();
      send_word(n, 1);
      idle_cycles(2);
      checks++;
      if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0 || byte_ready !== 1'b0) begin
         $display("FAIL bad_header_%h: error=%b done=%b hold=%b ready=%b required=1/0/0/0", n, error, done, cpu_hold, byte_ready);
      end else passes++;
      checks++;
      if (wr_addr_q.size() != 0) begin
         $display("FAIL bad_header_writes_%h: got=%0d required=0", n, wr_addr_q.size());
      end else passes++;
   endtask

   task automatic test_bad_checksum();
      clear_log();
      pulse_start();
      send_word(32'h00000001, 0);
      send_word(32'h1000FFFF, 0);
      send_word(32'h00000000, 0);
      checks++;
      if (error !== 1'b1 || done !== 1'b0 || words_loaded !== 9'd1) begin
         $display("FAIL bad_checksum_status: error=%b done=%b words=%0d required=1/0/1", error, done, words_loaded);
      end else passes++;
      checks++;
      if (wr_addr_q.size() != 1 || wr_addr_q[0] !== 32'h0 || wr_data_q[0] !== 32'h1000FFFF) begin
         $display("FAIL bad_checksum_writes: count=%0d required=1 at 0 with 1000ffff", wr_addr_q.size());
      end else passes++;
   endtask

   task automatic test_abort();
      clear_log();
      pulse_start();
      send_word(32'h00000002, 0);
      send_word(32'h11223344, 0);
      send_byte(8'h55, 0);
      send_byte(8'h66, 0);
      pulse_start();
      idle_cycles(2);
      checks++;
      if (wr_addr_q.size() != 1 || words_loaded !== 9'd0 || dbg_state !== ST_HEADER) begin
         $display("FAIL abort_state: writes=%0d words=%0d state=%0d required=1/0/%0d", wr_addr_q.size(), words_loaded, dbg_state, ST_HEADER);
      end else passes++;
      send_word(32'h00000001, 0);
      send_word(32'hAABBCCDD, 1);
      send_word(32'hAABBCCDD, 0);
      checks++;
      if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 32'h0 || wr_addr_q[1] !== 32'h0 ||
          wr_data_q[0] !== 32'h11223344 || wr_data_q[1] !== 32'hAABBCCDD || done !== 1'b1) begin
         $display("FAIL abort_restart: writes=%0d done=%b required=2 writes at 0, done=1", wr_addr_q.size(), done);
      end else passes++;
   endtask

   task automatic test_reset_mid_word();
      clear_log();
      pulse_start();
      send_word(32'h00000001, 0);
      send_byte(8'hDE, 0);
      send_byte(8'hAD, 0);
      send_byte(8'hBE, 0);
      byte_valid = 1'b1;
      byte_data  = 8'hEF;
      #2;
      reset = 1'b0;
      @(negedge clk);
      byte_valid = 1'b0;
      checks++;
      if ({byte_ready, im_write_en, cpu_hold, done, error} !== 5'b0 || words_loaded !== 9'd0 ||
          im_address !== 32'd0 || im_write_data !== 32'd0 || dbg_state !== ST_IDLE) begin
         $display("FAIL reset_mid_outputs: flags=%b words=%0d state=%0d required=00000/0/%0d",
                  {byte_ready, im_write_en, cpu_hold, done, error}, words_loaded, dbg_state, ST_IDLE);
      end else passes++;
      idle_cycles(2);
      checks++;
      if (wr_addr_q.size() != 0) begin
         $display("FAIL reset_mid_writes: got=%0d required=0", wr_addr_q.size());
      end else passes++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_max_words();
      logic [31:0] w;
      logic [31:0] sum;
      int bad;
      clear_log();
      sum = 32'd0;
      @(posedge clk);
      #1;
      pulse_start();
      send_word(32'h00000100, 2);
      for (int i = 0; i < MAX_WORDS; i++) begin
         w = $urandom;
         exp_q.push_back(w);
         sum = sum ^ w;
         send_word(w, 2);
      end
      send_word(sum, 2);
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || words_loaded !== 9'd256) begin
         $display("FAIL max_status: done=%b error=%b words=%0d required=1/0/256", done, error, words_loaded);
      end else passes++;
      checks++;
      if (wr_addr_q.size() != MAX_WORDS || wr_addr_q[wr_addr_q.size()-1] !== 32'h3FC) begin
         $display("FAIL max_last_addr: count=%0d required=256 ending at 3fc", wr_addr_q.size());
      end else passes++;
      bad = 0;
      for (int i = 0; i < wr_addr_q.size() && i < MAX_WORDS; i++)
         if (wr_addr_q[i] !== 32'(i * 4) || wr_data_q[i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0) begin
         $display("FAIL max_contents: mismatched=%0d required=0", bad);
      end else passes++;
   endtask

   initial begin
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      reset      = 1'b1;
      #1;
      test_reset();
      test_basic_load();
      test_bad_header(32'h00000000);
      test_bad_header(32'h00000101);
      test_bad_checksum();
      test_abort();
      test_reset_mid_word();
      test_max_words();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
